rgmii_rx_nibble_assembler: RTL and testbench
============================================

Name: rgmii_rx_nibble_assembler

Overview:
- Receive-side decoder, the counterpart of the transmit path's byte-to-nibble split at 10/100M.
- Sits between the RGMII PHY interface's GMII receive outputs and the GMII receive MAC, in the gmii_rx_clk domain.
- At 10/100M, pairs one nibble per clock into bytes, aligns to SFD and produces a byte-strobe clock enable. At 1000M, registers the data straight through.
- Also decodes RGMII in-band link status during inter-frame gaps.

Parameters:
- STATUS_FILTER, 4: consecutive identical inter-frame status cycles required before the status outputs update (1..15).
- STAT_WIDTH, 16: width of the optional statistics counters.

Ports:
- clk  input  1  receive clock (gmii_rx_clk from the PHY interface).
- rst_n  input  1  asynchronous active-low reset.
- speed  input  2  2'b10 1G, 2'b01 100M, 2'b00 10M; 2'b11 treated as 1G.
- in_rxd  input  8  GMII rxd from the PHY interface; [3:0] = rising-edge nibble.
- in_rx_dv  input  1  GMII rx_dv.
- in_rx_er  input  1  GMII rx_er.
- out_rxd  output  8  assembled byte.
- out_rx_dv  output  1  byte valid within a frame.
- out_rx_er  output  1  byte error.
- out_rx_clk_en  output  1  one-cycle strobe qualifying out_rxd/out_rx_dv/out_rx_er.
- link_up  output  1  in-band link status.
- link_speed  output  2  in-band speed, same encoding as speed.
- link_full_duplex  output  1  in-band duplex.
- link_status_valid  output  1  set once the first filtered status is accepted.
- stat_frames  output  STAT_WIDTH  frames completed (optional feature).
- stat_odd_nibble  output  STAT_WIDTH  frames ending on an odd nibble (optional feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0, FSM in IDLE, filter counter 0.
  - Asserting reset mid-frame drops the frame silently; no error byte is emitted.
- Speed is latched in IDLE only. A change of speed during a frame takes effect after dv falls.
- 1G path:
  - out_rxd/dv/er equal the inputs delayed by 1 cycle.
  - out_rx_clk_en=1 every cycle.
  - The FSM stays in IDLE.
- 10/100 path: nibble n = in_rxd[3:0] each cycle. FSM states:
  - IDLE:
    - On dv=1 go to SYNC with prev_nib=n.
    - out_rx_clk_en=0 every cycle spent in IDLE.
  - SYNC:
    - On dv=1 with n==4'hD and prev_nib==4'h5: next cycle emit byte 8'hD5, dv=1, clk_en=1, then go to LO.
    - Otherwise update prev_nib.
    - Preamble bytes are not emitted.
    - If dv falls while in SYNC, return to IDLE with no output.
  - LO:
    - On dv=1 store n as low nibble, go to HI.
    - On dv=0 go to IDLE. This is a clean end of frame; stat_frames increments.
  - HI:
    - On dv=1, next cycle emit byte {n, low}, dv=1, clk_en=1, er = OR of the er inputs of both nibbles; go to LO.
    - On dv=0 (odd nibble count), next cycle emit {4'h0, low} with dv=1, er=1, clk_en=1; go to IDLE. stat_frames and stat_odd_nibble both increment.
- Latency: a byte appears 1 cycle after its high nibble is sampled.
- out_rx_dv and out_rx_er are only meaningful when out_rx_clk_en=1; both are 0 otherwise.
- Outside a frame at 10/100, an input with dv=0 and er=1 (false carrier) is ignored.
- In-band status:
  - Sampled only when in_rx_dv=0 and in_rx_er=0, in any speed mode.
  - Decode: rxd[0]=link, rxd[2:1]=speed, rxd[3]=duplex.
  - A 4-bit candidate plus counter: the counter resets to 1 when the candidate changes and saturates at STATUS_FILTER.
  - On reaching STATUS_FILTER, the outputs update the next cycle and link_status_valid is set.
  - A cycle with dv=1 or er=1 resets the counter to 0.
- Simultaneous events: SFD detection and dv fall cannot coincide, because dv=0 has priority and the frame is discarded.

Optional Feature:
- Macro RGMII_RX_NIBBLE_STATS_EN.
- Defined:
  - stat_frames and stat_odd_nibble are STAT_WIDTH counters.
  - They wrap at 2^STAT_WIDTH and are cleared by reset.
  - They count 10/100 frames only; 1G frames are not counted.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package rgmii_pkg:
  - Speed encodings: SPEED_10M, SPEED_100M, SPEED_1G.
  - Preamble nibble 4'h5, SFD nibble 4'hD, SFD byte 8'hD5.
  - FSM state enum: IDLE, SYNC, LO, HI.
- Sub-module rgmii_inband_status_filter: status decode and consecutive-match filter, isolated from the assembler FSM.

Test Plan:
- 1G: speed=2'b10, drive bytes 55,55,D5,AA with dv=1 -> the same bytes appear 1 cycle later, clk_en held at 1.
- 100M: drive nibbles 5×15, D, then 1,2,3,4 -> out bytes D5, 21, 43, each with a one-cycle clk_en pulse, then a clean frame end and stat_frames=1.
- 10M odd end: drive SFD then nibbles A,B,C, then dv=0 -> bytes BA, then 0C with er=1; stat_odd_nibble=1.
- Error: 100M frame with in_rx_er=1 on the high nibble of the second data byte -> exactly that byte has out_rx_er=1.
- In-band: dv=0, er=0, rxd=4'b1101 for 3 cycles then 4 cycles -> link_up=1, link_speed=2'b10, link_full_duplex=1 only after the 4th consecutive match; link_status_valid=1.
- Reset mid-frame: pull rst_n low during LO -> all outputs 0 immediately; after release, a new frame is received correctly.

Source files
------------

// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared encodings, FSM state type and in-band status layout for the
// RGMII receive nibble assembler.
package rgmii_pkg;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;
  localparam logic [7:0] SFD_BYTE     = 8'hD5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LO   = 2'd2,
    HI   = 2'd3
  } rx_state_e;

  // Bit layout matches the inter-frame rxd[3:0] status nibble.
  typedef struct packed {
    logic       full_duplex;
    logic [1:0] speed;
    logic       link;
  } inband_status_t;

  // The reserved code 2'b11 is handled as gigabit.
  function automatic logic is_gig(input logic [1:0] spd);
    logic gig;
    case (spd)
      SPEED_10M:  gig = 1'b0;
      SPEED_100M: gig = 1'b0;
      SPEED_1G:   gig = 1'b1;
      default:    gig = 1'b1;
    endcase
    return gig;
  endfunction

endpackage

// File: rtl/rgmii_inband_status_filter.sv
// rgmii_inband_status_filter: decodes the inter-frame status nibble and only
// publishes it after STATUS_FILTER consecutive identical samples.
module rgmii_inband_status_filter
  import rgmii_pkg::*;
#(
  parameter int unsigned STATUS_FILTER = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rxd_i,
  input  logic       rx_dv_i,
  input  logic       rx_er_i,
  output logic       link_up_o,
  output logic [1:0] link_speed_o,
  output logic       link_full_duplex_o,
  output logic       link_status_valid_o
);

  localparam logic [3:0] FILTER_MAX = 4'(STATUS_FILTER);

  inband_status_t cand_q, cand_d;
  inband_status_t status_q, status_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           valid_q, valid_d;

  // Candidate tracking, saturating match count, and publish once saturated
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    valid_d  = valid_q;
    if (rx_dv_i || rx_er_i) begin
      cnt_d = 4'd0;
    end else if ((cnt_q == 4'd0) || (inband_status_t'(rxd_i) != cand_q)) begin
      cand_d = inband_status_t'(rxd_i);
      cnt_d  = 4'd1;
    end else if (cnt_q < FILTER_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (cnt_q == FILTER_MAX) begin
      status_d = cand_q;
      valid_d  = 1'b1;
    end else begin
      status_d = status_q;
      valid_d  = valid_q;
    end
  end

  // Filter state and published status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= inband_status_t'(4'h0);
      cnt_q    <= 4'd0;
      status_q <= inband_status_t'(4'h0);
      valid_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      valid_q  <= valid_d;
    end
  end

  assign link_up_o           = status_q.link;
  assign link_speed_o        = status_q.speed;
  assign link_full_duplex_o  = status_q.full_duplex;
  assign link_status_valid_o = valid_q;

endmodule

// File: rtl/rgmii_rx_nibble_assembler.sv
// rgmii_rx_nibble_assembler: pairs 10/100 nibbles into SFD-aligned bytes with a
// byte strobe, passes 1G bytes through. Optional counters: RGMII_RX_NIBBLE_STATS_EN.
module rgmii_rx_nibble_assembler
  import rgmii_pkg::*;
#(
  parameter int unsigned STATUS_FILTER = 4,
  parameter int unsigned STAT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            speed,
  input  logic [7:0]            in_rxd,
  input  logic                  in_rx_dv,
  input  logic                  in_rx_er,
  output logic [7:0]            out_rxd,
  output logic                  out_rx_dv,
  output logic                  out_rx_er,
  output logic                  out_rx_clk_en,
  output logic                  link_up,
  output logic [1:0]            link_speed,
  output logic                  link_full_duplex,
  output logic                  link_status_valid,
  output logic [STAT_WIDTH-1:0] stat_frames,
  output logic [STAT_WIDTH-1:0] stat_odd_nibble
);

  rx_state_e  state_q, state_d;
  logic [1:0] speed_q, speed_d;
  logic [3:0] prev_nib_q, prev_nib_d;
  logic [3:0] low_q, low_d;
  logic       low_er_q, low_er_d;
  logic [7:0] rxd_q, rxd_d;
  logic       dv_q, dv_d, er_q, er_d, en_q, en_d;
  logic [3:0] nib_s;
  logic       gig_s;

  assign nib_s = in_rxd[3:0];
  assign gig_s = is_gig(speed_q);

  // Speed latch, gigabit pass-through and 10/100 nibble-pairing FSM
  always_comb begin
    state_d    = state_q;
    prev_nib_d = prev_nib_q;
    low_d      = low_q;
    low_er_d   = low_er_q;
    rxd_d      = 8'h00;
    dv_d       = 1'b0;
    er_d       = 1'b0;
    en_d       = 1'b0;
    // Holding speed while dv is high keeps a gigabit frame intact across a change.
    if ((state_q == IDLE) && !in_rx_dv) begin
      speed_d = speed;
    end else begin
      speed_d = speed_q;
    end
    if (gig_s) begin
      rxd_d   = in_rxd;
      dv_d    = in_rx_dv;
      er_d    = in_rx_er;
      en_d    = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_rx_dv) begin
            state_d    = SYNC;
            prev_nib_d = nib_s;
          end else begin
            state_d = IDLE;
          end
        end
        SYNC: begin
          if (!in_rx_dv) begin
            state_d = IDLE;
          end else if ((nib_s == SFD_NIB) && (prev_nib_q == PREAMBLE_NIB)) begin
            rxd_d   = SFD_BYTE;
            dv_d    = 1'b1;
            en_d    = 1'b1;
            state_d = LO;
          end else begin
            prev_nib_d = nib_s;
          end
        end
        LO: begin
          if (in_rx_dv) begin
            low_d    = nib_s;
            low_er_d = in_rx_er;
            state_d  = HI;
          end else begin
            state_d = IDLE;
          end
        end
        HI: begin
          if (in_rx_dv) begin
            rxd_d   = {nib_s, low_q};
            dv_d    = 1'b1;
            er_d    = in_rx_er | low_er_q;
            en_d    = 1'b1;
            state_d = LO;
          end else begin
            // Frame ended mid-byte: flag the half byte as an error.
            rxd_d   = {4'h0, low_q};
            dv_d    = 1'b1;
            er_d    = 1'b1;
            en_d    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, nibble holding and registered byte outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      speed_q    <= 2'b00;
      prev_nib_q <= 4'h0;
      low_q      <= 4'h0;
      low_er_q   <= 1'b0;
      rxd_q      <= 8'h00;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      prev_nib_q <= prev_nib_d;
      low_q      <= low_d;
      low_er_q   <= low_er_d;
      rxd_q      <= rxd_d;
      dv_q       <= dv_d;
      er_q       <= er_d;
      en_q       <= en_d;
    end
  end

  assign out_rxd       = rxd_q;
  assign out_rx_dv     = dv_q;
  assign out_rx_er     = er_q;
  assign out_rx_clk_en = en_q;

  rgmii_inband_status_filter #(
    .STATUS_FILTER(STATUS_FILTER)
  ) u_status (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rxd_i               (in_rxd[3:0]),
    .rx_dv_i             (in_rx_dv),
    .rx_er_i             (in_rx_er),
    .link_up_o           (link_up),
    .link_speed_o        (link_speed),
    .link_full_duplex_o  (link_full_duplex),
    .link_status_valid_o (link_status_valid)
  );

`ifdef RGMII_RX_NIBBLE_STATS_EN
  logic [STAT_WIDTH-1:0] frames_q, odd_q;
  logic                  frame_end_s, odd_end_s;

  assign frame_end_s = !gig_s && !in_rx_dv && ((state_q == LO) || (state_q == HI));
  assign odd_end_s   = !gig_s && !in_rx_dv && (state_q == HI);

  // Wrapping 10/100 frame and odd-nibble counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= {STAT_WIDTH{1'b0}};
      odd_q    <= {STAT_WIDTH{1'b0}};
    end else begin
      if (frame_end_s) begin
        frames_q <= frames_q + STAT_WIDTH'(1);
      end else begin
        frames_q <= frames_q;
      end
      if (odd_end_s) begin
        odd_q <= odd_q + STAT_WIDTH'(1);
      end else begin
        odd_q <= odd_q;
      end
    end
  end

  assign stat_frames     = frames_q;
  assign stat_odd_nibble = odd_q;
`else
  assign stat_frames     = {STAT_WIDTH{1'b0}};
  assign stat_odd_nibble = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rgmii_rx_nibble_assembler.sv
// Directed scoreboard bench for rgmii_rx_nibble_assembler: 1G pass-through,
// 100M/10M assembly, error propagation, in-band status filter, mid-frame reset.
module tb_rgmii_rx_nibble_assembler;

`ifdef RGMII_RX_NIBBLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  speed;
  logic [7:0]  in_rxd;
  logic        in_rx_dv, in_rx_er;
  logic [7:0]  out_rxd;
  logic        out_rx_dv, out_rx_er, out_rx_clk_en;
  logic        link_up, link_full_duplex, link_status_valid;
  logic [1:0]  link_speed;
  logic [15:0] stat_frames, stat_odd_nibble;

  logic [9:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b0;
  logic        g1_mode  = 1'b0;

  always #5 clk = ~clk;

  rgmii_rx_nibble_assembler #(.STATUS_FILTER(4), .STAT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .speed(speed),
    .in_rxd(in_rxd), .in_rx_dv(in_rx_dv), .in_rx_er(in_rx_er),
    .out_rxd(out_rxd), .out_rx_dv(out_rx_dv), .out_rx_er(out_rx_er),
    .out_rx_clk_en(out_rx_clk_en),
    .link_up(link_up), .link_speed(link_speed), .link_full_duplex(link_full_duplex),
    .link_status_valid(link_status_valid),
    .stat_frames(stat_frames), .stat_odd_nibble(stat_odd_nibble)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: samples 1ns after the active edge
  always @(posedge clk) begin
    logic [9:0] e;
    #1;
    if (mon_en) begin
      if (g1_mode) chk("gig_clk_en", 32'(out_rx_clk_en), 32'd1);
      if (out_rx_clk_en === 1'b1) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_strobe: observed byte %h dv %b er %b, expected no strobe",
                 out_rxd, out_rx_dv, out_rx_er);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("byte_rxd", 32'(out_rxd), 32'(e[9:2]));
          chk("byte_dv",  32'(out_rx_dv), 32'(e[1]));
          chk("byte_er",  32'(out_rx_er), 32'(e[0]));
        end
      end else begin
        chk("idle_dv_er", {30'd0, out_rx_dv, out_rx_er}, 32'd0);
      end
    end
  end

  task automatic drv(input logic [7:0] d, input logic dv, input logic er);
    @(negedge clk);
    in_rxd   = d;
    in_rx_dv = dv;
    in_rx_er = er;
  endtask

  task automatic nib(input logic [3:0] n, input logic er);
    drv({4'h0, n}, 1'b1, er);
  endtask

  task automatic idle(input int k);
    repeat (k) drv(8'h00, 1'b0, 1'b1);
  endtask

  task automatic flush(input string tag);
    idle(3);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic preamble_sfd(input int k);
    repeat (k) nib(4'h5, 1'b0);
    mon_en = 1'b1;
    nib(4'hD, 1'b0);
    exp_q.push_back({8'hD5, 1'b1, 1'b0});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rxd"},    32'(out_rxd), 32'd0);
    chk({tag, "_dv"},     32'(out_rx_dv), 32'd0);
    chk({tag, "_er"},     32'(out_rx_er), 32'd0);
    chk({tag, "_clk_en"}, 32'(out_rx_clk_en), 32'd0);
    chk({tag, "_link"},   {28'd0, link_up, link_speed, link_full_duplex}, 32'd0);
    chk({tag, "_valid"},  32'(link_status_valid), 32'd0);
    chk({tag, "_frames"}, 32'(stat_frames), 32'd0);
    chk({tag, "_odd"},    32'(stat_odd_nibble), 32'd0);
  endtask

  initial begin
    logic [9:0] g1_tab [6];
    g1_tab = '{ {8'h00, 1'b0, 1'b1}, {8'h55, 1'b1, 1'b0}, {8'h55, 1'b1, 1'b0},
                {8'hD5, 1'b1, 1'b0}, {8'hAA, 1'b1, 1'b0}, {8'h00, 1'b0, 1'b1} };
    rst_n = 1'b1; speed = 2'b00; in_rxd = 8'h00; in_rx_dv = 1'b0; in_rx_er = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // In-band status: 3 matches then a break must not publish; 4 matches must
    repeat (3) drv(8'h0D, 1'b0, 1'b0);
    idle(2);
    chk("inband_3_valid", 32'(link_status_valid), 32'd0);
    chk("inband_3_link",  32'(link_up), 32'd0);
    repeat (4) drv(8'h0D, 1'b0, 1'b0);
    idle(2);
    chk("inband_4_link",   32'(link_up), 32'd1);
    chk("inband_4_speed",  32'(link_speed), 32'd2);
    chk("inband_4_duplex", 32'(link_full_duplex), 32'd1);
    chk("inband_4_valid",  32'(link_status_valid), 32'd1);

    // 1G pass-through, one entry expected per cycle
    speed = 2'b10;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      drv(g1_tab[i][9:2], g1_tab[i][1], g1_tab[i][0]);
      exp_q.push_back(g1_tab[i]);
      mon_en  = 1'b1;
      g1_mode = 1'b1;
    end
    @(posedge clk);
    #2;
    mon_en  = 1'b0;
    g1_mode = 1'b0;
    chk("gig_drained", 32'(exp_q.size()), 32'd0);

    // 100M clean frame: D5, 21, 43
    speed = 2'b01;
    idle(2);
    preamble_sfd(15);
    nib(4'h1, 1'b0); nib(4'h2, 1'b0); exp_q.push_back({8'h21, 1'b1, 1'b0});
    nib(4'h3, 1'b0); nib(4'h4, 1'b0); exp_q.push_back({8'h43, 1'b1, 1'b0});
    flush("m100_drained");
    chk("m100_frames", 32'(stat_frames), STATS ? 32'd1 : 32'd0);
    chk("m100_odd",    32'(stat_odd_nibble), 32'd0);

    // 100M with er on the high nibble of the second data byte
    preamble_sfd(7);
    nib(4'h1, 1'b0); nib(4'h2, 1'b0); exp_q.push_back({8'h21, 1'b1, 1'b0});
    nib(4'h3, 1'b0); nib(4'h4, 1'b1); exp_q.push_back({8'h43, 1'b1, 1'b1});
    nib(4'h5, 1'b0); nib(4'h6, 1'b0); exp_q.push_back({8'h65, 1'b1, 1'b0});
    flush("err_drained");
    chk("err_frames", 32'(stat_frames), STATS ? 32'd2 : 32'd0);

    // 10M odd nibble end: BA then 0C with er
    speed = 2'b00;
    idle(2);
    preamble_sfd(5);
    nib(4'hA, 1'b0); nib(4'hB, 1'b0); exp_q.push_back({8'hBA, 1'b1, 1'b0});
    nib(4'hC, 1'b0);
    drv(8'h00, 1'b0, 1'b1); exp_q.push_back({8'h0C, 1'b1, 1'b1});
    flush("odd_drained");
    chk("odd_frames", 32'(stat_frames), STATS ? 32'd3 : 32'd0);
    chk("odd_count",  32'(stat_odd_nibble), STATS ? 32'd1 : 32'd0);

    // Reset while in LO, then a fresh frame
    preamble_sfd(3);
    @(negedge clk);
    rst_n = 1'b0; in_rx_dv = 1'b0; in_rx_er = 1'b1;
    #1 chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    preamble_sfd(3);
    nib(4'h7, 1'b0); nib(4'h8, 1'b0); exp_q.push_back({8'h87, 1'b1, 1'b0});
    flush("post_reset_drained");
    chk("post_reset_frames", 32'(stat_frames), STATS ? 32'd1 : 32'd0);
    chk("post_reset_odd",    32'(stat_odd_nibble), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
